// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, default line timing, command bytes.
package ps2_pkg;

   localparam int unsigned DATA_W             = 8;
   localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
   localparam int unsigned DEF_REQ_CYCLES     = 250;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;

   localparam logic [DATA_W-1:0] CMD_SET_LED = 8'hED;
   localparam logic [DATA_W-1:0] CMD_RESET   = 8'hFF;
   localparam logic [DATA_W-1:0] CMD_ENABLE  = 8'hF4;
   localparam logic [DATA_W-1:0] RSP_ACK     = 8'hFA;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_e;

   // Byte latched at acceptance together with its precomputed odd parity bit
   typedef struct packed {
      logic              parity;
      logic [DATA_W-1:0] data;
   } ps2_tx_frame_t;

   function automatic logic odd_parity(input logic [DATA_W-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a clock falling-edge detector.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_ps2_clk,
   input  logic i_ps2_dat,
   output logic o_clk_s,
   output logic o_dat_s,
   output logic o_clk_fall_c
);

   logic r_clk_meta;
   logic r_clk_s;
   logic r_clk_prev;
   logic r_dat_meta;
   logic r_dat_s;

   // Idle bus is high, so everything resets to 1 to avoid a false edge after reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_clk_meta <= 1'b1;
         r_clk_s    <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_s    <= 1'b1;
      end else begin
         r_clk_meta <= i_ps2_clk;
         r_clk_s    <= r_clk_meta;
         r_clk_prev <= r_clk_s;
         r_dat_meta <= i_ps2_dat;
         r_dat_s    <= r_dat_meta;
      end
   end

   assign o_clk_s      = r_clk_s;
   assign o_dat_s      = r_dat_s;
   assign o_clk_fall_c = r_clk_prev & ~r_clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ack check).
// Optional device-clock watchdog in SHIFT/ACK/WAIT_IDLE enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int unsigned REQ_CYCLES     = DEF_REQ_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              CLOCK_50,
   input  logic              KEY0,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   input  logic              ps2_clk_in,
   input  logic              ps2_dat_in,
   output logic              ps2_clk_oe,
   output logic              ps2_dat_oe,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              tx_err
);

   localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = 4;

   ps2_tx_state_e r_state,  w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [BIT_W-1:0] r_bit, w_bit_next;
   ps2_tx_frame_t r_frame,  w_frame_next;
   logic r_clk_oe, w_clk_oe_next;
   logic r_dat_oe, w_dat_oe_next;
   logic r_done,   w_done_next;
   logic r_err,    w_err_next;
   logic r_ready;
   logic r_busy;

   logic w_clk_s;
   logic w_dat_s;
   logic w_clk_fall;
   logic w_timeout;

   ps2_line_sync u_sync (
      .clk          (CLOCK_50),
      .rst_n        (KEY0),
      .i_ps2_clk    (ps2_clk_in),
      .i_ps2_dat    (ps2_dat_in),
      .o_clk_s      (w_clk_s),
      .o_dat_s      (w_dat_s),
      .o_clk_fall_c (w_clk_fall)
   );

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            w_to_active;

   assign w_to_active = (r_state == ST_SHIFT) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);

   // Counts cycles since the last device clock fall; held at zero outside the device-clocked states
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         r_to_cnt <= '0;
      end else if (!w_to_active || w_clk_fall) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign w_timeout = w_to_active && !w_clk_fall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   // Never fires: without the watchdog the FSM waits for the device indefinitely
   assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   // State and registered outputs
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_frame  <= '0;
         r_clk_oe <= 1'b0;
         r_dat_oe <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_bit    <= w_bit_next;
         r_frame  <= w_frame_next;
         r_clk_oe <= w_clk_oe_next;
         r_dat_oe <= w_dat_oe_next;
         r_done   <= w_done_next;
         r_err    <= w_err_next;
         r_ready  <= (w_state_next == ST_IDLE);
         r_busy   <= (w_state_next != ST_IDLE);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_bit_next    = r_bit;
      w_frame_next  = r_frame;
      w_clk_oe_next = r_clk_oe;
      w_dat_oe_next = r_dat_oe;
      w_done_next   = 1'b0;
      w_err_next    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_clk_oe_next = 1'b0;
            w_dat_oe_next = 1'b0;
            w_cnt_next    = '0;
            w_bit_next    = '0;
            if (tx_valid && r_ready) begin
               w_frame_next.data   = tx_data;
               w_frame_next.parity = odd_parity(tx_data);
               w_clk_oe_next       = 1'b1;
               w_state_next        = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
               w_cnt_next    = '0;
               w_dat_oe_next = 1'b1;
               w_state_next  = ST_REQ;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end

         ST_REQ: begin
            if (r_cnt == CNT_W'(REQ_CYCLES - 1)) begin
               w_cnt_next    = '0;
               w_bit_next    = '0;
               w_clk_oe_next = 1'b0;
               w_state_next  = ST_SHIFT;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end

         // r_bit counts falls already seen: 0..7 data, 8 parity, 9 stop
         ST_SHIFT: begin
            if (w_clk_fall) begin
               w_bit_next = r_bit + BIT_W'(1);
               if (r_bit < BIT_W'(8)) begin
                  w_dat_oe_next = ~r_frame.data[r_bit[2:0]];
               end else if (r_bit == BIT_W'(8)) begin
                  w_dat_oe_next = ~r_frame.parity;
               end else begin
                  w_dat_oe_next = 1'b0;
                  w_state_next  = ST_ACK;
               end
            end else if (w_timeout) begin
               w_clk_oe_next = 1'b0;
               w_dat_oe_next = 1'b0;
               w_err_next    = 1'b1;
               w_state_next  = ST_IDLE;
            end
         end

         ST_ACK: begin
            if (w_clk_fall) begin
               if (!w_dat_s) begin
                  w_state_next = ST_WAIT_IDLE;
               end else begin
                  w_err_next   = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end else if (w_timeout) begin
               w_clk_oe_next = 1'b0;
               w_dat_oe_next = 1'b0;
               w_err_next    = 1'b1;
               w_state_next  = ST_IDLE;
            end
         end

         ST_WAIT_IDLE: begin
            if (w_clk_s && w_dat_s) begin
               w_done_next  = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_timeout) begin
               w_clk_oe_next = 1'b0;
               w_dat_oe_next = 1'b0;
               w_err_next    = 1'b1;
               w_state_next  = ST_IDLE;
            end
         end

         default: begin
            w_clk_oe_next = 1'b0;
            w_dat_oe_next = 1'b0;
            w_state_next  = ST_IDLE;
         end
      endcase
   end

   assign tx_ready   = r_ready;
   assign tx_busy    = r_busy;
   assign tx_done    = r_done;
   assign tx_err     = r_err;
   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;

endmodule
